slv_guard_rst_ctrl: RTL and testbench

Reset-handshake responder for the subordinate guard. It consumes the guard's reset request and isolates the subordinate port. It then drives a timed active-low reset pulse into the subordinate and returns the reset-status/clear handshake that releases the guard's monitor state. It sits between the guard (rst_req_o/rst_stat_i pair) and the subordinate's reset input, and includes bounded retry plus a sticky error when recovery fails.

---
 rtl/slv_guard_rst_ctrl.sv | 119 +++++++++++
 tb/tb_slv_guard_rst_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_guard_rst_ctrl.sv
// Reset-handshake responder for the subordinate guard: isolate, pulse the
// subordinate reset, settle, then acknowledge the guard, with bounded retry and sticky error.
module slv_guard_rst_ctrl #(
  parameter int unsigned IsoTimeout      = 32,
  parameter int unsigned RstHoldCycles   = 16,
  parameter int unsigned RstSettleCycles = 8,
  parameter int unsigned ClearTimeout    = 64,
  parameter int unsigned MaxRetries      = 3,
  parameter int unsigned CntWidth        = 8,
  parameter int unsigned RstCntWidth     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rst_req_i,
  input  logic                   sw_rst_i,
  input  logic                   err_clr_i,
  output logic                   rst_stat_o,
  output logic                   isolate_o,
  input  logic                   isolated_i,
  output logic                   sub_rst_no,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [RstCntWidth-1:0] rst_cnt_o
);

  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  localparam logic [CntWidth-1:0] IsoLast    = CntWidth'(IsoTimeout - 1);
  localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(RstSettleCycles - 1);
  localparam logic [CntWidth-1:0] ClearLast  = CntWidth'(ClearTimeout - 1);
  localparam logic [RetryW-1:0]   RetryMax   = RetryW'(MaxRetries);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISOLATE,
    ST_ASSERT,
    ST_SETTLE,
    ST_CLEAR,
    ST_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] timer_q;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                cnt_inc;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst_req_i || sw_rst_i) state_d = ST_ISOLATE;
      end
      ST_ISOLATE: begin
        if (isolated_i || (timer_q == IsoLast)) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (timer_q == HoldLast) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_q == SettleLast) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!rst_req_i) begin
          state_d = ST_IDLE;
          retry_d = '0;
          cnt_inc = 1'b1;
        end else if (timer_q == ClearLast) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_ASSERT;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (err_clr_i) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      rst_cnt_o  <= '0;
      rst_stat_o <= 1'b0;
      isolate_o  <= 1'b0;
      sub_rst_no <= 1'b1;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      // IDLE and ERROR have no timed exit, so the timer rests there instead of wrapping.
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if ((state_q != ST_IDLE) && (state_q != ST_ERROR)) begin
        timer_q <= timer_q + 1'b1;
      end
      if (cnt_inc && (rst_cnt_o != '1)) rst_cnt_o <= rst_cnt_o + 1'b1;
      rst_stat_o <= (state_d == ST_CLEAR);
      isolate_o  <= (state_d != ST_IDLE);
      busy_o     <= (state_d != ST_IDLE);
      sub_rst_no <= !((state_d == ST_ASSERT) || (state_d == ST_ERROR));
      err_o      <= (state_d == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Self-checking bench: per-cycle comparison of the reset handshake against a
// timeline model derived from the phase durations and handshake rules.
module tb_slv_guard_rst_ctrl;

  localparam int IsoTimeout   = 32;
  localparam int Hold         = 16;
  localparam int Settle       = 8;
  localparam int ClearTimeout = 64;
  localparam int MaxRetries   = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rst_req_i = 1'b0;
  logic       sw_rst_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       isolated_i = 1'b0;
  logic       rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o;
  logic [7:0] rst_cnt_o;
  logic       s_rst_stat, s_isolate, s_sub_rst_n, s_busy, s_err;
  logic [1:0] s_rst_cnt;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  // Timeline model state for the scenario in progress
  int a_st[MaxRetries+1];
  int n_att;
  int end_cyc;
  bit ends_err;

  always #5 clk_i = ~clk_i;

  slv_guard_rst_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rst_req_i(rst_req_i), .sw_rst_i(sw_rst_i),
    .err_clr_i(err_clr_i), .rst_stat_o(rst_stat_o), .isolate_o(isolate_o),
    .isolated_i(isolated_i), .sub_rst_no(sub_rst_no), .busy_o(busy_o),
    .err_o(err_o), .rst_cnt_o(rst_cnt_o)
  );

  slv_guard_rst_ctrl #(.RstCntWidth(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .rst_req_i(rst_req_i), .sw_rst_i(sw_rst_i),
    .err_clr_i(err_clr_i), .rst_stat_o(s_rst_stat), .isolate_o(s_isolate),
    .isolated_i(isolated_i), .sub_rst_no(s_sub_rst_n), .busy_o(s_busy),
    .err_o(s_err), .rst_cnt_o(s_rst_cnt)
  );

  // Phase codes: 0 idle, 1 isolate, 2 assert, 3 settle, 4 clear, 5 error
  function automatic int phase_at(int c);
    int nx;
    if (c < 1) return 0;
    if (c < a_st[0]) return 1;
    for (int i = 0; i < n_att; i++) begin
      nx = (i + 1 < n_att) ? a_st[i+1] : end_cyc;
      if (c >= a_st[i] && c < nx) begin
        if (c < a_st[i] + Hold) return 2;
        if (c < a_st[i] + Hold + Settle) return 3;
        return 4;
      end
    end
    return ends_err ? 5 : 0;
  endfunction

  function automatic logic [4:0] outs_for(int ph);
    return {ph == 4, ph != 0, !(ph == 2 || ph == 5), ph != 0, ph == 5};
  endfunction

  // Trigger in cycle 0; isolated_i high from cycle k; rst_req_i high for cycles < d.
  task automatic build_model(input int k, input int d);
    int a, cl, first;
    a = (k < 1) ? 1 : k;
    if (a > IsoTimeout) a = IsoTimeout;
    a = a + 1;
    n_att = 0;
    ends_err = 1'b0;
    forever begin
      a_st[n_att] = a;
      n_att++;
      cl = a + Hold + Settle;
      first = (d > cl) ? d : cl;
      if (first <= cl + ClearTimeout - 1) begin
        end_cyc = first + 1;
        break;
      end else if (n_att - 1 < MaxRetries) begin
        a = cl + ClearTimeout;
      end else begin
        end_cyc = cl + ClearTimeout;
        ends_err = 1'b1;
        break;
      end
    end
  endtask

  // Call aligned at posedge+1 with the DUT idle.
  task automatic run_scenario(input string name, input int k, input int d,
                              input bit sw, input int sw2);
    int horizon;
    logic [4:0] exp_v, act_v;
    int exp_cnt;
    build_model(k, d);
    horizon = end_cyc + (ends_err ? 3 : 2);
    rst_req_i  = (d > 0);
    isolated_i = (k <= 0);
    sw_rst_i   = sw;
    for (int c = 1; c <= horizon; c++) begin
      @(posedge clk_i); #1;
      exp_v = outs_for(phase_at(c));
      act_v = {rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s outputs cycle %0d: got %b expected %b (rst_stat,isolate,sub_rst_n,busy,err)",
                 name, c, act_v, exp_v);
      end
      exp_cnt = model_cnt + ((!ends_err && c >= end_cyc) ? 1 : 0);
      checks++;
      if (rst_cnt_o !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL %s rst_cnt cycle %0d: got %0d expected %0d", name, c, rst_cnt_o, exp_cnt);
      end
      rst_req_i  = (c < d);
      isolated_i = (c >= k);
      sw_rst_i   = (c == sw2);
    end
    isolated_i = 1'b0;
    if (!ends_err) model_cnt++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rst_req_i = 1'b0; sw_rst_i = 1'b0; err_clr_i = 1'b0; isolated_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #13;
    checks++;
    if ({rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o} !== 5'b00100 || rst_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got %b cnt %0d expected 00100 cnt 0",
               {rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o}, rst_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_nominal();
    run_scenario("nominal", 3, 29, 1'b0, -1);
  endtask

  task automatic test_iso_timeout();
    run_scenario("iso_timeout", 1000, 58, 1'b0, -1);
  endtask

  task automatic test_random();
    int k, cl, d, mode;
    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(1, 40);
      cl = ((k > IsoTimeout) ? IsoTimeout : k) + 1 + Hold + Settle;
      mode = $urandom_range(0, 2);
      if (mode == 0)      d = $urandom_range(1, cl);
      else if (mode == 1) d = cl + $urandom_range(0, 10);
      else                d = cl + ClearTimeout + $urandom_range(0, 40);
      run_scenario("random", k, d, 1'b0, -1);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
    end
  endtask

  task automatic test_retry_error();
    run_scenario("retry_error", 2, 1 << 30, 1'b0, -1);
    rst_req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o} !== 5'b01011) begin
      errors++;
      $display("FAIL error_hold: got %b expected 01011", {rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o});
    end
    err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
    checks++;
    if ({rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o} !== 5'b00100 || rst_cnt_o !== 8'(model_cnt)) begin
      errors++;
      $display("FAIL err_clear: got %b cnt %0d expected 00100 cnt %0d",
               {rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o}, rst_cnt_o, model_cnt);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_sw_reset();
    // second pulse lands in ASSERT (starts cycle 2) and must be ignored
    run_scenario("sw_reset", 1, 0, 1'b1, 7);
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || rst_cnt_o !== 8'(model_cnt)) begin
      errors++;
      $display("FAIL sw_second_ignored: got busy %b cnt %0d expected busy 0 cnt %0d",
               busy_o, rst_cnt_o, model_cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_s;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      run_scenario("saturation", 1, 0, 1'b1, -1);
      exp_s = (n > 3) ? 3 : n;
      checks++;
      if (s_rst_cnt !== 2'(exp_s) || {s_rst_stat, s_isolate, s_sub_rst_n, s_busy, s_err} !== 5'b00100) begin
        errors++;
        $display("FAIL saturation n=%0d: got cnt %0d outs %b expected cnt %0d outs 00100",
                 n, s_rst_cnt, {s_rst_stat, s_isolate, s_sub_rst_n, s_busy, s_err}, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid_assert();
    rst_req_i = 1'b1;
    isolated_i = 1'b1;
    // ASSERT starts in cycle 2; cycle 12 is the 11th hold cycle
    repeat (12) @(posedge clk_i);
    #1;
    checks++;
    if (sub_rst_no !== 1'b0) begin
      errors++;
      $display("FAIL mid_assert_pre: got sub_rst_n %b expected 0", sub_rst_no);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o} !== 5'b00100 || rst_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL mid_assert_reset: got %b cnt %0d expected 00100 cnt 0",
               {rst_stat_o, isolate_o, sub_rst_no, busy_o, err_o}, rst_cnt_o);
    end
    do_reset();
    repeat (2) @(posedge clk_i);
    #1;
    run_scenario("restart", 4, 30, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_iso_timeout();
    test_random();
    test_retry_error();
    test_sw_reset();
    test_saturation();
    test_reset_mid_assert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
